// File: rtl/retire_trace_if.sv
// Retire-side inputs and trace-side stream of the retire trace buffer.
// The core/consumer side uses master; the buffer uses slave.
interface retire_trace_if #(
    parameter int XLEN      = 32,
    parameter int NUM_LANES = 2,
    parameter int SEQ_W     = 32
);
    logic [NUM_LANES-1:0]      retire_valid;
    logic [NUM_LANES*XLEN-1:0] retire_pc;
    logic [NUM_LANES*32-1:0]   retire_instr;
    logic [NUM_LANES*5-1:0]    retire_rd;
    logic [NUM_LANES*XLEN-1:0] retire_rd_data;

    logic                      trace_valid;
    logic                      trace_ready;
    logic [XLEN-1:0]           trace_pc;
    logic [31:0]               trace_instr;
    logic [4:0]                trace_rd;
    logic [XLEN-1:0]           trace_rd_data;
    logic [SEQ_W-1:0]          trace_seq;
    logic                      trace_gap;

    modport master (
        output retire_valid, retire_pc, retire_instr, retire_rd, retire_rd_data, trace_ready,
        input  trace_valid, trace_pc, trace_instr, trace_rd, trace_rd_data, trace_seq, trace_gap
    );

    modport slave (
        input  retire_valid, retire_pc, retire_instr, retire_rd, retire_rd_data, trace_ready,
        output trace_valid, trace_pc, trace_instr, trace_rd, trace_rd_data, trace_seq, trace_gap
    );
endinterface

// File: rtl/retire_trace_buffer.sv
// Circular buffer of retired instructions, streamed out in program order with
// sequence numbers and loss reporting (drop-newest or overwrite-oldest).
module retire_trace_buffer #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 16,
    parameter int NUM_LANES = 2,
    parameter int SEQ_W     = 32,
    parameter bit OVERWRITE = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    retire_trace_if.slave          bus,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [SEQ_W-1:0]       dropped_count_o
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int SW1 = SEQ_W + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [XLEN-1:0]  mem_pc_q    [DEPTH];
    logic [31:0]      mem_instr_q [DEPTH];
    logic [4:0]       mem_rd_q    [DEPTH];
    logic [XLEN-1:0]  mem_data_q  [DEPTH];
    logic [SEQ_W-1:0] mem_seq_q   [DEPTH];
    logic             mem_gap_q   [DEPTH];

    ptr_t             head_q, head_d, tail_q, tail_d;
    cnt_t             count_q, count_d;
    logic [SEQ_W-1:0] seq_q, seq_d, drop_q, drop_d;
    logic             pend_q, pend_d;

    cnt_t             n_valid, cnt_base, free, n_store, n_drop;
    logic             head_vld, pop, pend_eff, ow_gap;
    ptr_t             head_base;
    logic [SW1-1:0]   drop_sum;

    logic             wr_en  [NUM_LANES];
    ptr_t             wr_ptr [NUM_LANES];
    logic [SEQ_W-1:0] wr_seq [NUM_LANES];
    logic             wr_gap [NUM_LANES];

    assign head_vld = (count_q != '0);

    always_comb begin
        cnt_t k;
        n_valid = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            n_valid = n_valid + cnt_t'(bus.retire_valid[i]);
        end

        // A flush discards the old contents, so the whole buffer is free and any pop is moot.
        pop      = head_vld && bus.trace_ready && !flush_i;
        cnt_base = flush_i ? '0 : count_q - cnt_t'(pop);
        free     = cnt_t'(DEPTH) - cnt_base;

        if (OVERWRITE) begin
            n_store = n_valid;
            n_drop  = (n_valid > free) ? n_valid - free : '0;
            count_d = cnt_base + n_store - n_drop;
        end else begin
            n_store = (n_valid > free) ? free : n_valid;
            n_drop  = n_valid - n_store;
            count_d = cnt_base + n_store;
        end

        head_base = flush_i ? tail_q : head_q + ptr_t'(pop);
        head_d    = OVERWRITE ? head_base + ptr_t'(n_drop) : head_base;
        tail_d    = tail_q + ptr_t'(n_store);
        ow_gap    = OVERWRITE && (n_drop != '0);

        // Stores precede discards within a cycle, so only the first store inherits the pending gap.
        pend_eff = pend_q && !flush_i;
        pend_d   = OVERWRITE ? 1'b0 : ((pend_eff && (n_store == '0)) || (n_drop != '0));

        seq_d    = seq_q + SEQ_W'(n_valid);
        drop_sum = {1'b0, drop_q} + SW1'(n_drop);
        drop_d   = drop_sum[SEQ_W] ? '1 : drop_sum[SEQ_W-1:0];

        k = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            wr_en[i]  = 1'b0;
            wr_ptr[i] = tail_q + ptr_t'(k);
            wr_seq[i] = seq_q + SEQ_W'(k);
            wr_gap[i] = pend_eff && (k == '0);
            if (bus.retire_valid[i]) begin
                wr_en[i] = (k < n_store);
                k        = k + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            seq_q   <= '0;
            drop_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            seq_q   <= seq_d;
            drop_q  <= drop_d;
            pend_q  <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (wr_en[i]) begin
                mem_pc_q[wr_ptr[i]]    <= bus.retire_pc[i*XLEN +: XLEN];
                mem_instr_q[wr_ptr[i]] <= bus.retire_instr[i*32 +: 32];
                mem_rd_q[wr_ptr[i]]    <= bus.retire_rd[i*5 +: 5];
                mem_data_q[wr_ptr[i]]  <= bus.retire_rd_data[i*XLEN +: XLEN];
                mem_seq_q[wr_ptr[i]]   <= wr_seq[i];
                mem_gap_q[wr_ptr[i]]   <= wr_gap[i];
            end
        end
        // Placed after the lane writes so it wins when the new head is also being written.
        if (ow_gap) begin
            mem_gap_q[head_d] <= 1'b1;
        end
    end

    assign bus.trace_valid   = head_vld;
    assign bus.trace_pc      = head_vld ? mem_pc_q[head_q]    : '0;
    assign bus.trace_instr   = head_vld ? mem_instr_q[head_q] : '0;
    assign bus.trace_rd      = head_vld ? mem_rd_q[head_q]    : '0;
    assign bus.trace_rd_data = head_vld ? mem_data_q[head_q]  : '0;
    assign bus.trace_seq     = head_vld ? mem_seq_q[head_q]   : '0;
    assign bus.trace_gap     = head_vld ? mem_gap_q[head_q]   : 1'b0;
    assign count_o           = count_q;
    assign dropped_count_o   = drop_q;
endmodule
